// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared constants and types for the instruction fetch front end
//
// Purpose : word size, the NOP encoding shown while no instruction is buffered,
//           the {instr, pc} buffer entry and the fetch FSM state encoding.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO of fetch entries with registered head
//
// Purpose : small circular buffer; head is read straight from the storage
//           registers, so it carries no combinational path from push_data.
// Ports   : clk, rst_n      clock, asynchronous active-low reset
//           push, push_data write an entry (ignored when full or flushing)
//           pop             drop the head entry (ignored when empty or flushing)
//           flush           empty the FIFO; wins over push and pop
//           count           number of stored entries (0..DEPTH)
//           head            oldest entry; RESET_VAL after reset
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int           DEPTH     = 2,
  parameter fetch_entry_t RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output fetch_entry_t             head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (count_q != CW'(DEPTH)) && !flush;
  assign do_pop  = pop && (count_q != '0) && !flush;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RESET_VAL;
      end
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC owner, credit-limited fetch issue and instruction buffer
//
// Purpose : issues word fetches while outstanding + buffered < FIFO_DEPTH, tags
//           each request with its PC, buffers returned words and hands them to
//           the datapath; redirects reload the PC, flush the buffer and drop the
//           responses of fetches already in flight.
// Ports   : clk, rst_n                       clock, asynchronous active-low reset
//           imem_req_valid/ready/addr        fetch request channel
//           imem_rsp_valid/data              in-order responses, no backpressure
//           instr_valid/ready, instr, instr_pc  buffered instruction to datapath
//           redirect_valid, redirect_pc      new fetch target (bits [1:0] ignored)
//           fetch_stall_cycles               only with IFETCH_PERF_CNT_EN defined:
//                                            cycles the datapath waited on fetch
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
`ifdef IFETCH_PERF_CNT_EN
  output logic [31:0] fetch_stall_cycles,
`endif
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int             CW          = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]    DEPTH_C     = (CW + 1)'(FIFO_DEPTH);
  localparam fetch_entry_t   RESET_ENTRY = {NOP_INSTR, RESET_PC};

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic          started_q;

  logic [CW-1:0] outstanding;
  logic [CW-1:0] occupancy;
  logic [CW-1:0] outstanding_post;
  logic [CW:0]   credits_used;
  logic          req_fire;
  logic          rsp_accept;
  logic          rsp_keep;
  logic          instr_pop;
  fetch_entry_t  tag_entry;
  fetch_entry_t  tag_head;
  fetch_entry_t  rsp_entry;
  fetch_entry_t  data_head;
  logic          unused_tag_instr;

  // started_q holds off the first request until the first edge after reset release.
  assign credits_used   = {1'b0, outstanding} + {1'b0, occupancy};
  assign imem_req_valid = started_q && !redirect_valid && (credits_used < DEPTH_C);
  assign imem_req_addr  = fetch_pc_q;

  assign req_fire   = imem_req_valid && imem_req_ready;
  // With nothing outstanding (e.g. a response to a fetch issued before reset) there is no tag.
  assign rsp_accept = imem_rsp_valid && (outstanding != '0);
  assign rsp_keep   = rsp_accept && (drop_cnt_q == '0) && !redirect_valid;
  assign instr_pop  = instr_valid && instr_ready;

  assign outstanding_post = outstanding + CW'(req_fire) - CW'(rsp_accept);

  // Tag entries only carry a PC; the instr field is unused.
  assign tag_entry        = {NOP_INSTR, fetch_pc_q};
  assign unused_tag_instr = ^tag_head.instr;
  assign rsp_entry        = {imem_rsp_data, tag_head.pc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
      started_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
      started_q  <= 1'b1;
    end
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    state_d    = state_q;

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    if (rsp_accept && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - 1'b1;
    end
    // A response landing in the redirect cycle is already excluded from outstanding_post.
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      drop_cnt_d = outstanding_post;
    end

    case (state_q)
      RUN: begin
        if (redirect_valid && (outstanding_post != '0)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drop_cnt_d == '0) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  fetch_fifo #(
    .DEPTH     (FIFO_DEPTH),
    .RESET_VAL (RESET_ENTRY)
  ) u_tag_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (req_fire),
    .push_data (tag_entry),
    .pop       (rsp_accept),
    .flush     (1'b0),
    .count     (outstanding),
    .head      (tag_head)
  );

  fetch_fifo #(
    .DEPTH     (FIFO_DEPTH),
    .RESET_VAL (RESET_ENTRY)
  ) u_instr_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rsp_keep),
    .push_data (rsp_entry),
    .pop       (instr_pop),
    .flush     (redirect_valid),
    .count     (occupancy),
    .head      (data_head)
  );

  assign instr_valid = (occupancy != '0);
  assign instr       = data_head.instr;
  assign instr_pc    = data_head.pc;

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (!instr_valid && instr_ready) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_stall_cycles;
`endif

  instruction_fetch dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .imem_req_valid     (imem_req_valid),
    .imem_req_ready     (imem_req_ready),
    .imem_req_addr      (imem_req_addr),
    .imem_rsp_valid     (imem_rsp_valid),
    .imem_rsp_data      (imem_rsp_data),
    .instr_valid        (instr_valid),
    .instr_ready        (instr_ready),
    .instr              (instr),
    .instr_pc           (instr_pc),
`ifdef IFETCH_PERF_CNT_EN
    .fetch_stall_cycles (fetch_stall_cycles),
`endif
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [31:0] fired[$];
  logic [31:0] taken_pc[$];
  logic [31:0] taken_instr[$];
  int          cyc;
  int          lat;
  int          n_cmp = 0;
  int          n_bad = 0;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] NONE = 32'hDEAD_BEEF;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] taken_at(input int i);
    return (taken_pc.size() > i) ? taken_pc[i] : NONE;
  endfunction

  function automatic logic [31:0] taken_instr_at(input int i);
    return (taken_instr.size() > i) ? taken_instr[i] : NONE;
  endfunction

  function automatic logic [31:0] fired_at(input int i);
    return (fired.size() > i) ? fired[i] : NONE;
  endfunction

  // One clock: present the memory response, observe handshakes, cross the edge.
  // Called and returns just after a falling edge.
  task automatic step();
    logic        fire;
    logic [31:0] fire_addr;
    logic        take;
    logic [31:0] take_pc;
    logic [31:0] take_instr;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc + 1) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_data(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    fire       = imem_req_valid && imem_req_ready;
    fire_addr  = imem_req_addr;
    take       = instr_valid && instr_ready;
    take_pc    = instr_pc;
    take_instr = instr;
    @(posedge clk);
    cyc++;
    if (fire) begin
      mem_q.push_back('{addr: fire_addr, due: cyc + lat});
      fired.push_back(fire_addr);
    end
    if (take) begin
      taken_pc.push_back(take_pc);
      taken_instr.push_back(take_instr);
    end
    @(negedge clk);
  endtask

  task automatic clear_logs();
    fired.delete();
    taken_pc.delete();
    taken_instr.delete();
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    instr_ready    = 1'b0;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    mem_q.delete();
    clear_logs();
    repeat (2) @(negedge clk);
    cyc = 0;
  endtask

  task automatic run_until_taken(input int n, input int max_cycles);
    for (int k = 0; k < max_cycles && taken_pc.size() < n; k++) begin
      step();
    end
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    @(negedge clk);

    // Reset state and fill latency, 1-cycle memory, datapath always ready.
    lat = 1;
    do_reset();
    check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", instr, NOP);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
`ifdef IFETCH_PERF_CNT_EN
    check("rst_stall_cnt", fetch_stall_cycles, 32'd0);
`endif
    instr_ready = 1'b1; imem_req_ready = 1'b1;
    rst_n = 1'b1;
    step();
    check("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("first_req_addr", imem_req_addr, 32'h0);
    step();
    check("fill_valid_e2", {31'b0, instr_valid}, 32'd0);
    step();
    check("fill_valid_e3", {31'b0, instr_valid}, 32'd1);
    check("fill_pc_e3", instr_pc, 32'h0);
    check("fill_instr_e3", instr, mem_data(32'h0));
    run_until_taken(4, 20);
    check("seq_pc0", taken_at(0), 32'h0);
    check("seq_pc1", taken_at(1), 32'h4);
    check("seq_pc2", taken_at(2), 32'h8);
    check("seq_pc3", taken_at(3), 32'hC);
    check("seq_instr3", taken_instr_at(3), mem_data(32'hC));

    // Redirect near the top of the address space: low bits forced, PC wraps.
    redirect(32'hFFFF_FFFE);
    clear_logs();
    run_until_taken(2, 20);
    check("wrap_pc0", taken_at(0), 32'hFFFF_FFFC);
    check("wrap_pc1", taken_at(1), 32'h0);

    // Datapath stalled: credits cap requests at FIFO_DEPTH.
    lat = 1;
    do_reset();
    imem_req_ready = 1'b1;
    rst_n = 1'b1;
    repeat (8) step();
    check("stall_fires", fired.size(), 32'd2);
    check("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
    clear_logs();
    instr_ready = 1'b1;
    run_until_taken(3, 20);
    check("resume_pc0", taken_at(0), 32'h0);
    check("resume_pc1", taken_at(1), 32'h4);
    check("resume_pc2", taken_at(2), 32'h8);
    check("resume_fetch", fired_at(0), 32'h8);

    // Two fetches in flight (latency 3), redirect drops both.
    lat = 3;
    do_reset();
    instr_ready = 1'b1; imem_req_ready = 1'b1;
    rst_n = 1'b1;
    step();
    redirect(32'h0000_0010);
    step();
    step();
    check("drain_setup", fired_at(1), 32'h14);
    redirect(32'h0000_0103);
    clear_logs();
    run_until_taken(1, 30);
    check("drain_next_req", fired_at(0), 32'h100);
    check("drain_first_pc", taken_at(0), 32'h100);
    check("drain_first_instr", taken_instr_at(0), mem_data(32'h100));

    // Redirect in the same cycle as the only outstanding response.
    lat = 3;
    do_reset();
    instr_ready = 1'b1; imem_req_ready = 1'b1;
    rst_n = 1'b1;
    step();
    step();
    imem_req_ready = 1'b0;
    step();
    step();
    check("same_cycle_setup", fired.size(), 32'd1);
    redirect(32'h0000_0040);
    clear_logs();
    imem_req_ready = 1'b1;
    lat = 1;
    run_until_taken(1, 20);
    check("same_cycle_req", fired_at(0), 32'h40);
    check("same_cycle_pc", taken_at(0), 32'h40);
    check("same_cycle_taken_n", taken_pc.size(), 32'd1);

    // Reset while a fetch is outstanding; its late response is ignored.
    lat = 3;
    do_reset();
    imem_req_ready = 1'b1;
    rst_n = 1'b1;
    repeat (5) step();
    check("mid_rst_pre_valid", {31'b0, instr_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
    check("mid_rst_pc", instr_pc, 32'h0);
    check("mid_rst_instr", instr, NOP);
    #1;
    rst_n = 1'b1;
    instr_ready = 1'b1;
    lat = 1;
    clear_logs();
    run_until_taken(1, 20);
    check("post_rst_pc", taken_at(0), 32'h0);
    check("post_rst_instr", taken_instr_at(0), mem_data(32'h0));

`ifdef IFETCH_PERF_CNT_EN
    // Memory refuses requests for 5 cycles, then 2 cycles of fill.
    lat = 1;
    do_reset();
    instr_ready = 1'b1;
    rst_n = 1'b1;
    repeat (5) step();
    imem_req_ready = 1'b1;
    step();
    step();
    check("perf_valid", {31'b0, instr_valid}, 32'd1);
    check("perf_stall_cnt", fetch_stall_cycles, 32'd7);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
